// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one unsigned 4-bit (a > b) comparator between NUM_REQ requesters.
// Optional feature macro CMP_EQ_EN adds a registered result_eq output (A == B).

module comparator_4bit (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic gt
);
  assign gt = ({a3, a2, a1, a0} > {b3, b2, b1, b0});
endmodule

module comparator_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   a_in,
  input  logic [4*NUM_REQ-1:0]   b_in,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   busy,
  output logic                   done,
  output logic                   result,
  output logic [ID_W-1:0]        result_id
`ifdef CMP_EQ_EN
  ,
  output logic                   result_eq
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    EVAL    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int                  CAND_W    = ID_W + 1;
  localparam logic [CAND_W-1:0]   NUM_REQ_C = CAND_W'(NUM_REQ);
  localparam logic [ID_W-1:0]     LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]  GNT_LSB   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic [ID_W-1:0]     rr_ptr_r, rr_ptr_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                result_r, result_s;
  logic [ID_W-1:0]     result_id_r, result_id_s;
  logic [3:0]          op_a_r, op_a_s;
  logic [3:0]          op_b_r, op_b_s;
  logic                gt_s;
  logic                win_found_s;
  logic [ID_W-1:0]     win_id_s;
  logic [CAND_W-1:0]   cand_s;

`ifdef CMP_EQ_EN
  logic                result_eq_r, result_eq_s;

  function automatic logic eq4(input logic [3:0] a, input logic [3:0] b);
    return &(a ~^ b);
  endfunction
`endif

  comparator_4bit u_cmp (
    .a0(op_a_r[0]), .a1(op_a_r[1]), .a2(op_a_r[2]), .a3(op_a_r[3]),
    .b0(op_b_r[0]), .b1(op_b_r[1]), .b2(op_b_r[2]), .b3(op_b_r[3]),
    .gt(gt_s)
  );

  // Winner search: first set req bit starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {ID_W{1'b0}};
    cand_s      = {CAND_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, rr_ptr_r} + CAND_W'(i);
      if (cand_s >= NUM_REQ_C) begin
        cand_s = cand_s - NUM_REQ_C;
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && req[cand_s[ID_W-1:0]]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s[ID_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and next-output logic; every output is taken from a register
  always_comb begin
    state_s     = state_r;
    rr_ptr_s    = rr_ptr_r;
    gnt_s       = gnt_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    result_s    = result_r;
    result_id_s = result_id_r;
    op_a_s      = op_a_r;
    op_b_s      = op_b_r;
`ifdef CMP_EQ_EN
    result_eq_s = result_eq_r;
`endif
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          gnt_s       = GNT_LSB << win_id_s;
          result_id_s = win_id_s;
          busy_s      = 1'b1;
          state_s     = CAPTURE;
        end else begin
          state_s = IDLE;
        end
      end
      CAPTURE: begin
        op_a_s  = a_in[{result_id_r, 2'b00} +: 4];
        op_b_s  = b_in[{result_id_r, 2'b00} +: 4];
        state_s = EVAL;
      end
      EVAL: begin
        result_s = gt_s;
`ifdef CMP_EQ_EN
        result_eq_s = eq4(op_a_r, op_b_r);
`endif
        done_s  = 1'b1;
        state_s = DONE;
      end
      DONE: begin
        // Pointer moves past the requester just served so it gets lowest priority next
        if (result_id_r == LAST_ID) begin
          rr_ptr_s = {ID_W{1'b0}};
        end else begin
          rr_ptr_s = result_id_r + {{(ID_W-1){1'b0}}, 1'b1};
        end
        gnt_s   = {NUM_REQ{1'b0}};
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        gnt_s   = {NUM_REQ{1'b0}};
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset (aborts any transaction)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {ID_W{1'b0}};
      gnt_r       <= {NUM_REQ{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= 1'b0;
      result_id_r <= {ID_W{1'b0}};
      op_a_r      <= 4'h0;
      op_b_r      <= 4'h0;
`ifdef CMP_EQ_EN
      result_eq_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      rr_ptr_r    <= rr_ptr_s;
      gnt_r       <= gnt_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      result_r    <= result_s;
      result_id_r <= result_id_s;
      op_a_r      <= op_a_s;
      op_b_r      <= op_b_s;
`ifdef CMP_EQ_EN
      result_eq_r <= result_eq_s;
`endif
    end
  end

  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign result_id = result_id_r;
`ifdef CMP_EQ_EN
  assign result_eq = result_eq_r;
`endif

endmodule

// File: tb/tb_comparator_arbiter.sv
// Scoreboard bench for comparator_arbiter: expected transactions are queued when
// requests are driven and compared whenever the DUT pulses done.

module tb_comparator_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] a_in;
  logic [4*NUM_REQ-1:0] b_in;
  logic [NUM_REQ-1:0]   gnt;
  logic                 busy;
  logic                 done;
  logic                 result;
  logic [ID_W-1:0]      result_id;
`ifdef CMP_EQ_EN
  logic                 result_eq;
`endif

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            res;
    logic            eq;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  comparator_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .done(done), .result(result), .result_id(result_id)
`ifdef CMP_EQ_EN
    , .result_eq(result_eq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    a_in[4*i +: 4] = a;
    b_in[4*i +: 4] = b;
  endtask

  // Expected result comes from the bench's own unsigned a > b reference
  task automatic expect_txn(input int id, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.id  = id[ID_W-1:0];
    e.res = (a > b);
    e.eq  = (a == b);
    sb_q.push_back(e);
  endtask

  // Requester side of the handshake: drop req at done & gnt, optionally re-request next cycle
  task automatic serve(input int count, input bit rearm);
    int served = 0;
    logic [NUM_REQ-1:0] pend = '0;
    for (int cyc = 0; cyc < 200 && served < count; cyc++) begin
      @(negedge clk);
      if (pend != '0) begin
        req  = req | pend;
        pend = '0;
      end
      if (done) begin
        served++;
        if (served == count) begin
          req = '0;
        end else begin
          req = req & ~gnt;
          if (rearm) pend = gnt;
        end
      end
    end
    if (served < count) check("serve_timeout", 32'(served), 32'(count));
  endtask

  task automatic wait_drain(input string tag);
    for (int cyc = 0; cyc < 20 && sb_q.size() != 0; cyc++) @(negedge clk);
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  32'(gnt), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_res"},  32'(result), 32'd0);
    check({tag, "_id"},   32'(result_id), 32'd0);
`ifdef CMP_EQ_EN
    check({tag, "_eq"},   32'(result_eq), 32'd0);
`endif
  endtask

  // Scoreboard monitor: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (busy === 1'b1) check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result_id", 32'(result_id), 32'(mon_e.id));
        check("result", 32'(result), 32'(mon_e.res));
        check("gnt_at_done", 32'(gnt), 32'd1 << mon_e.id);
`ifdef CMP_EQ_EN
        check("result_eq", 32'(result_eq), 32'(mon_e.eq));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Warm-up: requester 1 wins (rr_ptr -> 2), leaves result=1 and id=1 behind
    set_ops(1, 4'd9, 4'd2); expect_txn(1, 4'd9, 4'd2);
    req = 4'b0010;
    serve(1, 1'b0);
    wait_drain("warmup_drain");

    // Reset held two cycles while requester 2 is in EVAL: aborted, no done
    @(negedge clk);
    set_ops(2, 4'd3, 4'd1);
    req = 4'b0100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_busy_before_rst", 32'(busy), 32'd1);
    check("t1_gnt_before_rst", 32'(gnt), 32'b0100);
    rst = 1'b1; req = '0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("t1_midrst");
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // All four requesting with equal operands: order 0,1,2,3,0 proves rr_ptr was reset
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, 4'd5, 4'd5);
    expect_txn(0, 4'd5, 4'd5); expect_txn(1, 4'd5, 4'd5);
    expect_txn(2, 4'd5, 4'd5); expect_txn(3, 4'd5, 4'd5);
    expect_txn(0, 4'd5, 4'd5);
    req = 4'b1111;
    serve(5, 1'b1);
    wait_drain("t3_drain");

    // Single requester 0: gnt at T+1, done at T+3
    @(negedge clk);
    set_ops(0, 4'd9, 4'd3); expect_txn(0, 4'd9, 4'd3);
    req = 4'b0001;
    @(posedge clk); #1;
    check("t2_gnt_t1", 32'(gnt), 32'b0001);
    check("t2_busy_t1", 32'(busy), 32'd1);
    @(posedge clk); #1 check("t2_done_t2", 32'(done), 32'd0);
    @(posedge clk); #1 check("t2_done_t3", 32'(done), 32'd1);
    @(negedge clk) req = '0;
    wait_drain("t2_drain");

    // Requester 2 drops req right after the grant: transaction still completes
    @(negedge clk);
    set_ops(2, 4'd4, 4'd12); expect_txn(2, 4'd4, 4'd12);
    req = 4'b0100;
    @(posedge clk); #1;
    req = '0;
    check("t5_gnt", 32'(gnt), 32'b0100);
    wait_drain("t5_drain");
    repeat (2) @(negedge clk);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_hold_id", 32'(result_id), 32'd2);
    check("t5_hold_res", 32'(result), 32'd0);

    // rr_ptr is now 3: requester 3 first, then wrap to 0
    set_ops(3, 4'd6, 4'd2); set_ops(0, 4'd1, 4'd1);
    expect_txn(3, 4'd6, 4'd2); expect_txn(0, 4'd1, 4'd1);
    req = 4'b1001;
    serve(2, 1'b0);
    wait_drain("t4_drain");

    // Edge operand values, one per requester; rr_ptr is 1 so order is 1,2,3,0
    @(negedge clk);
    set_ops(0, 4'd15, 4'd14); set_ops(1, 4'd0, 4'd15);
    set_ops(2, 4'd8, 4'd7);   set_ops(3, 4'd7, 4'd8);
    expect_txn(1, 4'd0, 4'd15); expect_txn(2, 4'd8, 4'd7);
    expect_txn(3, 4'd7, 4'd8);  expect_txn(0, 4'd15, 4'd14);
    req = 4'b1111;
    serve(4, 1'b0);
    wait_drain("t6_drain");
    repeat (3) @(negedge clk);
    check("end_busy", 32'(busy), 32'd0);
    check("end_gnt", 32'(gnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
